// File: rtl/chacha20_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// chacha20_stream_ctrl_if
// Bundles every handshake/bus signal of chacha20_stream_ctrl so the controller
// and its environment connect through one port.
//
// Signal groups:
//   host_csr_*      host Avalon-MM write port (write/address/writedata, waitrequest)
//   cfg_*, busy,    message start/length and status
//   done
//   core_csr_*      write port towards the ChaCha20 core CSRs
//   core_st_*       512-bit keystream pad stream from the core
//   in_*            32-bit data-in Avalon-ST stream
//   out_*           32-bit data-out Avalon-ST stream, out_last marks the final word
//
// Modports:
//   slave  - the controller itself
//   master - the surrounding system (host, core, stream source/sink)
// -----------------------------------------------------------------------------
interface chacha20_stream_ctrl_if #(
    parameter int LEN_W = 16
);
    logic             host_csr_write;
    logic [5:0]       host_csr_address;
    logic [31:0]      host_csr_writedata;
    logic             host_waitrequest;

    logic             cfg_start;
    logic [LEN_W-1:0] cfg_len;
    logic             busy;
    logic             done;

    logic             core_csr_write;
    logic [5:0]       core_csr_address;
    logic [31:0]      core_csr_writedata;

    logic [511:0]     core_st_data;
    logic             core_st_valid;
    logic             core_st_ready;

    logic [31:0]      in_data;
    logic             in_valid;
    logic             in_ready;

    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport slave (
        input  host_csr_write, host_csr_address, host_csr_writedata,
        output host_waitrequest,
        input  cfg_start, cfg_len,
        output busy, done,
        output core_csr_write, core_csr_address, core_csr_writedata,
        input  core_st_data, core_st_valid,
        output core_st_ready,
        input  in_data, in_valid,
        output in_ready,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    modport master (
        output host_csr_write, host_csr_address, host_csr_writedata,
        input  host_waitrequest,
        output cfg_start, cfg_len,
        input  busy, done,
        input  core_csr_write, core_csr_address, core_csr_writedata,
        output core_st_data, core_st_valid,
        input  core_st_ready,
        output in_data, in_valid,
        input  in_ready,
        input  out_data, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/chacha20_stream_ctrl.sv
// -----------------------------------------------------------------------------
// chacha20_stream_ctrl
// Drives the ChaCha20 keystream core to encrypt/decrypt a message of cfg_len
// 32-bit words. Pads are requested with CONTROL writes (address 6'h20, data =
// pads-1) in chunks of at most MAX_CHUNK. Each 512-bit pad is held in a local
// buffer and XORed word by word with the input stream, so the core can already
// work on the next pad while the current one is being consumed.
//
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   bus (slave)    host CSR port, cfg/status, core CSR and pad stream,
//                  data-in and data-out streams (see chacha20_stream_ctrl_if)
//
// Parameters:
//   LEN_W          width of the message length in words
//   MAX_CHUNK      pads per CONTROL write, 1..32 (core's 5-bit pad counter)
//
// Build option:
//   CHACHA_STREAM_CTRL_OUT_REG_EN - when defined, out_data/out_valid/out_last
//   come from a skid-free output register (1-cycle latency) and done fires on
//   the final word's output handshake. Undefined: combinational XOR path.
// -----------------------------------------------------------------------------
module chacha20_stream_ctrl #(
    parameter int LEN_W     = 16,
    parameter int MAX_CHUNK = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    chacha20_stream_ctrl_if.slave bus
);
    localparam logic [5:0] CONTROL_ADDR = 6'h20;
    localparam int         BLK_W        = LEN_W - 3;
    localparam int         CHUNK_W      = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_KS,
        S_XOR
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_words_left;
    logic [BLK_W-1:0]   r_blocks_left;
    logic [CHUNK_W-1:0] r_chunk_left;
    logic [3:0]         r_word_idx;
    logic [511:0]       r_ks_buf;
    logic               r_done;

    logic [BLK_W-1:0]   w_cfg_blocks;
    logic [CHUNK_W-1:0] w_chunk_n;
    logic               w_pad_take;
    logic               w_word_take;
    logic               w_in_xor;
    logic               w_in_ready;
    logic               w_last_word;
    logic [31:0]        w_ks_word;

    // ceil(cfg_len / 16): whole blocks plus one for any partial tail.
    assign w_cfg_blocks = BLK_W'(bus.cfg_len[LEN_W-1:4]) + BLK_W'(|bus.cfg_len[3:0]);
    assign w_chunk_n    = (r_blocks_left > BLK_W'(MAX_CHUNK)) ? CHUNK_W'(MAX_CHUNK)
                                                              : CHUNK_W'(r_blocks_left);

    assign w_in_xor    = (r_state == S_XOR);
    assign w_last_word = (r_words_left == LEN_W'(1));
    assign w_ks_word   = r_ks_buf[{r_word_idx, 5'd0} +: 32];

    // The core keeps valid high after its last pad; only accept while pads of
    // the current chunk are still owed. ISSUE keeps ready low so a stale valid
    // from the previous chunk is never taken.
    assign bus.core_st_ready = (r_state == S_WAIT_KS) && (r_chunk_left != '0);
    assign w_pad_take        = bus.core_st_ready && bus.core_st_valid;

    assign bus.busy             = (r_state != S_IDLE);
    assign bus.host_waitrequest = (r_state != S_IDLE);

    // Host writes reach the core only while idle; CONTROL belongs to this block.
    always_comb begin
        // NOTE: each output gets a default before the case so every path assigns it and no latch is inferred.
        bus.core_csr_write     = 1'b0;
        bus.core_csr_address   = '0;
        bus.core_csr_writedata = '0;
        case (r_state)
            S_IDLE: begin
                bus.core_csr_write     = bus.host_csr_write && (bus.host_csr_address != CONTROL_ADDR);
                bus.core_csr_address   = bus.host_csr_address;
                bus.core_csr_writedata = bus.host_csr_writedata;
            end
            S_ISSUE: begin
                bus.core_csr_write     = 1'b1;
                bus.core_csr_address   = CONTROL_ADDR;
                bus.core_csr_writedata = 32'(w_chunk_n) - 32'd1;
            end
            default: ;
        endcase
    end

`ifdef CHACHA_STREAM_CTRL_OUT_REG_EN
    localparam logic DONE_ON_EXIT = 1'b0;

    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_last;

    assign w_in_ready  = w_in_xor && (!r_out_valid || bus.out_ready);
    assign w_word_take = w_in_ready && bus.in_valid;

    // The register keeps draining after the FSM has left XOR.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_word_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.in_data ^ w_ks_word;
            r_out_last  <= w_last_word;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.done      = r_done || (r_out_valid && bus.out_ready && r_out_last);
`else
    localparam logic DONE_ON_EXIT = 1'b1;

    assign w_in_ready  = w_in_xor && bus.out_ready;
    assign w_word_take = w_in_ready && bus.in_valid;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_in_xor && bus.in_valid;
    assign bus.out_data  = w_in_xor ? (bus.in_data ^ w_ks_word) : '0;
    assign bus.out_last  = w_in_xor && w_last_word;
    assign bus.done      = r_done;
`endif

    // NOTE: the pad buffer is pure datapath, only read after a pad is captured, so it carries no reset.
    always_ff @(posedge clock) begin
        if (w_pad_take) begin
            r_ks_buf <= bus.core_st_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_words_left  <= '0;
            r_blocks_left <= '0;
            r_chunk_left  <= '0;
            r_word_idx    <= '0;
            r_done        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cfg_start) begin
                        if (bus.cfg_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_words_left  <= bus.cfg_len;
                            r_blocks_left <= w_cfg_blocks;
                            r_state       <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_chunk_left  <= w_chunk_n;
                    r_blocks_left <= r_blocks_left - BLK_W'(w_chunk_n);
                    r_state       <= S_WAIT_KS;
                end
                S_WAIT_KS: begin
                    if (w_pad_take) begin
                        r_chunk_left <= r_chunk_left - CHUNK_W'(1);
                        r_word_idx   <= '0;
                        r_state      <= S_XOR;
                    end
                end
                S_XOR: begin
                    if (w_word_take) begin
                        r_word_idx   <= r_word_idx + 4'd1;
                        r_words_left <= r_words_left - LEN_W'(1);
                        if (w_last_word) begin
                            // Unused words of a partial final pad are simply dropped.
                            r_state <= S_IDLE;
                            r_done  <= DONE_ON_EXIT;
                        end else if (r_word_idx == 4'd15) begin
                            r_state <= (r_chunk_left != '0) ? S_WAIT_KS : S_ISSUE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
